dm_store_fwd_buf: RTL and testbench

- Parametrised store-data forwarding block for the M stage.
- Produces the DM write data for a store residing in M. It selects, youngest first, among:
  - the live W-stage register write;
  - a DEPTH-entry history of register writes committed since the store entered M;
  - the M pipeline-register rt value.
- This removes stale store data when M stalls while younger-than-read writes retire.
- Sits between the M pipeline register and the DM write-data input.

---
 rtl/dm_store_fwd_buf.sv | 98 +++++++++
 tb/tb_dm_store_fwd_buf.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dm_store_fwd_buf.sv
// Store-data forwarding for the M stage: picks the youngest write to the store's rt
// register among the live W write, a short commit history, and the M pipeline value.
module dm_store_fwd_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          m_load,
  input  logic                          m_store,
  input  logic [ADDR_W-1:0]             m_rt_addr,
  input  logic [DATA_W-1:0]             m_rt_data,
  input  logic                          wb_we,
  input  logic [ADDR_W-1:0]             wb_addr,
  input  logic [DATA_W-1:0]             wb_data,
  output logic [DATA_W-1:0]             dm_wdata,
  output logic                          fwd_hit,
  output logic [$clog2(DEPTH+2)-1:0]    fwd_src,
  output logic                          hist_ovf
);

  localparam int SRC_W = $clog2(DEPTH+2);
  localparam int CNT_W = SRC_W;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DEPTH);

  logic [DEPTH-1:0]  hist_vld;
  logic [ADDR_W-1:0] hist_addr [DEPTH];
  logic [DATA_W-1:0] hist_data [DEPTH];
  logic [CNT_W-1:0]  commit_cnt;
  logic              ovf_q;

  logic recordable;
  logic hist_we;

  // DM qualifies the write with m_store; the selection itself never looks at it.
  logic unused_store;
  assign unused_store = m_store;

  assign recordable = wb_we && (wb_addr != '0);
  assign hist_we    = recordable && !m_load && !reset;

  // History control: valid bits, commit counter, sticky overflow.
  always_ff @(posedge clk) begin
    if (reset || m_load) begin
      hist_vld   <= '0;
      commit_cnt <= '0;
      ovf_q      <= 1'b0;
    end else if (recordable) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        hist_vld[k] <= hist_vld[k-1];
      end
      hist_vld[0] <= 1'b1;
      if (commit_cnt != CNT_SAT) begin
        commit_cnt <= commit_cnt + 1'b1;
      end
      if (commit_cnt >= CNT_LIM) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // History payload: shifts with the valid bits, never reset.
  always_ff @(posedge clk) begin
    if (hist_we) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        hist_addr[k] <= hist_addr[k-1];
        hist_data[k] <= hist_data[k-1];
      end
      hist_addr[0] <= wb_addr;
      hist_data[0] <= wb_data;
    end
  end

  // Zero-latency selection; scanning oldest to youngest lets the youngest match win.
  always_comb begin
    dm_wdata = m_rt_data;
    fwd_src  = '0;
    if (m_rt_addr != '0) begin
      if (recordable && (wb_addr == m_rt_addr)) begin
        dm_wdata = wb_data;
        fwd_src  = SRC_W'(1);
      end else begin
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (hist_vld[k] && (hist_addr[k] == m_rt_addr)) begin
            dm_wdata = hist_data[k];
            fwd_src  = SRC_W'(k + 2);
          end
        end
      end
    end
  end

  assign fwd_hit  = (fwd_src != '0);
  assign hist_ovf = ovf_q;

endmodule

// File: tb/tb_dm_store_fwd_buf.sv
// Directed bench for dm_store_fwd_buf: a DEPTH=2 and a DEPTH=3 instance share the
// same stimulus and are checked against hand-computed values.
module tb_dm_store_fwd_buf;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              m_load;
  logic              m_store;
  logic [ADDR_W-1:0] m_rt_addr;
  logic [DATA_W-1:0] m_rt_data;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic [DATA_W-1:0] d2_wdata, d3_wdata;
  logic              d2_hit, d3_hit;
  logic [1:0]        d2_src;
  logic [2:0]        d3_src;
  logic              d2_ovf, d3_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dm_store_fwd_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .m_load(m_load), .m_store(m_store),
    .m_rt_addr(m_rt_addr), .m_rt_data(m_rt_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .dm_wdata(d2_wdata), .fwd_hit(d2_hit), .fwd_src(d2_src), .hist_ovf(d2_ovf)
  );

  dm_store_fwd_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .m_load(m_load), .m_store(m_store),
    .m_rt_addr(m_rt_addr), .m_rt_data(m_rt_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .dm_wdata(d3_wdata), .fwd_hit(d3_hit), .fwd_src(d3_src), .hist_ovf(d3_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  task automatic do_load();
    m_load = 1'b1;
    tick();
    m_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; m_load = 1'b0; m_store = 1'b1;
    m_rt_addr = 5'd8; m_rt_data = 32'h1111_1111;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_d2_data", d2_wdata, 32'h1111_1111);
    chk("rst_d2_hit",  d2_hit,   0);
    chk("rst_d2_src",  d2_src,   0);
    chk("rst_d2_ovf",  d2_ovf,   0);
    chk("rst_d3_data", d3_wdata, 32'h1111_1111);
    chk("rst_d3_ovf",  d3_ovf,   0);

    // Live W match, then the same write found in history entry 0.
    do_load();
    wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'hAAAA_0001;
    #1;
    chk("live_data", d2_wdata, 32'hAAAA_0001);
    chk("live_src",  d2_src,   1);
    chk("live_hit",  d2_hit,   1);
    tick();
    wb_we = 1'b0;
    #1;
    chk("h0_d2_data", d2_wdata, 32'hAAAA_0001);
    chk("h0_d2_src",  d2_src,   2);
    chk("h0_d3_src",  d3_src,   2);

    // Youngest-first among history entries; DEPTH=2 overflows on the third commit.
    do_load();
    commit(5'd8, 32'h1);
    commit(5'd9, 32'h2);
    commit(5'd8, 32'h3);
    m_rt_addr = 5'd8; #1;
    chk("yng_d3_data8", d3_wdata, 32'h3);
    chk("yng_d3_src8",  d3_src,   2);
    chk("yng_d2_data8", d2_wdata, 32'h3);
    m_rt_addr = 5'd9; #1;
    chk("yng_d3_data9", d3_wdata, 32'h2);
    chk("yng_d3_src9",  d3_src,   3);
    chk("yng_d2_src9",  d2_src,   3);
    chk("yng_d2_ovf",   d2_ovf,   1);
    chk("yng_d3_ovf",   d3_ovf,   0);

    // Commit in the m_load cycle is forwarded live but not recorded.
    m_rt_addr = 5'd8; m_rt_data = 32'h1234_5678;
    m_load = 1'b1; wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h5;
    #1;
    chk("ld_live_src",  d2_src,   1);
    chk("ld_live_data", d2_wdata, 32'h5);
    tick();
    m_load = 1'b0; wb_we = 1'b0;
    #1;
    chk("ld_norec_data", d2_wdata, 32'h1234_5678);
    chk("ld_norec_src",  d2_src,   0);
    chk("ld_norec_hit",  d2_hit,   0);
    chk("ld_norec_d3",   d3_src,   0);
    chk("ld_ovf_clr",    d2_ovf,   0);

    // Overflow boundary at DEPTH=2.
    commit(5'd3, 32'h33);
    commit(5'd4, 32'h44);
    chk("ovf_pre", d2_ovf, 0);
    commit(5'd5, 32'h55);
    m_rt_addr = 5'd3; m_rt_data = 32'hCAFE_0000; #1;
    chk("ovf_d2",      d2_ovf,   1);
    chk("ovf_d3",      d3_ovf,   0);
    chk("ovf_d2_data", d2_wdata, 32'hCAFE_0000);
    chk("ovf_d2_src",  d2_src,   0);
    chk("ovf_d3_data", d3_wdata, 32'h33);
    chk("ovf_d3_src",  d3_src,   4);
    m_rt_addr = 5'd5; #1;
    chk("ovf_d2_h0", d2_wdata, 32'h55);
    do_load();
    chk("ovf_clr", d2_ovf, 0);

    // Writes to $0: never forwarded, never recorded, counter untouched.
    commit(5'd6, 32'h66);
    commit(5'd7, 32'h77);
    m_rt_addr = 5'd0; m_rt_data = 32'h0;
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
    #1;
    chk("z_data", d2_wdata, 32'h0);
    chk("z_hit",  d2_hit,   0);
    chk("z_src",  d2_src,   0);
    tick();
    wb_we = 1'b0;
    m_rt_addr = 5'd6; m_rt_data = 32'hFFFF_0000; #1;
    chk("z_norec_data", d2_wdata, 32'h66);
    chk("z_norec_src",  d2_src,   3);
    chk("z_nocnt_ovf",  d2_ovf,   0);

    // Reset mid-history, with a commit in the same cycle that must be dropped.
    reset = 1'b1; wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h1;
    tick();
    reset = 1'b0; wb_we = 1'b0;
    m_rt_addr = 5'd7; m_rt_data = 32'hBEEF; #1;
    chk("mr_d2_data", d2_wdata, 32'hBEEF);
    chk("mr_d2_src",  d2_src,   0);
    chk("mr_d3_data", d3_wdata, 32'hBEEF);
    chk("mr_d3_hit",  d3_hit,   0);
    m_rt_addr = 5'd6; #1;
    chk("mr_d2_old", d2_wdata, 32'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
